// File: rtl/execute_stage.sv
// Execute stage of the Z pipeline: ALU / immediate move, condition codes,
// and registered dstE/valE, dstM/valM results for write-back.
module execute_stage #(
  parameter logic [3:0] NOREG = 4'hF,
  parameter int         NREGS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_ifun,
  input  logic [3:0]  d_rA,
  input  logic [3:0]  d_rB,
  input  logic [31:0] d_valA,
  input  logic [31:0] d_valB,
  input  logic [15:0] d_valC,
  input  logic        stall,
  input  logic        bubble,
  output logic        e_valid,
  output logic [3:0]  e_dstE,
  output logic [31:0] e_valE,
  output logic [3:0]  e_dstM,
  output logic [31:0] e_valM,
  output logic [2:0]  cc,
  output logic        halted,
  output logic        ins_err,
  output logic [15:0] retired
);

  logic [31:0] alu_r;
  logic        alu_of;
  logic        ra_ok, rb_ok;

  logic        nxt_valid;
  logic [3:0]  nxt_dstE, nxt_dstM;
  logic [31:0] nxt_valE, nxt_valM;
  logic [2:0]  nxt_cc;
  logic        nxt_halted, nxt_err;
  logic [15:0] nxt_retired;

  assign ra_ok = (32'(d_rA) < 32'(NREGS));
  assign rb_ok = (32'(d_rB) < 32'(NREGS));

  always_comb begin
    alu_r  = '0;
    alu_of = 1'b0;
    case (d_ifun[1:0])
      2'd0: begin
        alu_r  = d_valA + d_valB;
        alu_of = (d_valA[31] == d_valB[31]) && (alu_r[31] != d_valA[31]);
      end
      2'd1: begin
        alu_r  = d_valA - d_valB;
        alu_of = (d_valA[31] != d_valB[31]) && (alu_r[31] != d_valA[31]);
      end
      2'd2:    alu_r = d_valA & d_valB;
      default: alu_r = d_valA ^ d_valB;
    endcase
  end

  // Defaults describe a bubble; only a valid, non-halted instruction overrides them.
  always_comb begin
    nxt_valid   = 1'b0;
    nxt_dstE    = NOREG;
    nxt_valE    = '0;
    nxt_dstM    = NOREG;
    nxt_valM    = '0;
    nxt_cc      = cc;
    nxt_halted  = halted;
    nxt_err     = ins_err;
    nxt_retired = retired;
    if (d_valid && !halted) begin
      case ({d_icode, d_ifun})
        8'h00: begin
          nxt_valid   = 1'b1;
          nxt_retired = retired + 16'd1;
        end
        8'h10: begin
          if (rb_ok) begin
            nxt_valid   = 1'b1;
            nxt_dstM    = d_rB;
            nxt_valM    = {16'h0, d_valC};
            nxt_retired = retired + 16'd1;
          end else begin
            nxt_err = 1'b1;
          end
        end
        8'h20, 8'h21, 8'h22, 8'h23: begin
          if (ra_ok) begin
            nxt_valid   = 1'b1;
            nxt_dstE    = d_rA;
            nxt_valE    = alu_r;
            nxt_cc      = {(alu_r == 32'd0), alu_r[31], alu_of};
            nxt_retired = retired + 16'd1;
          end else begin
            nxt_err = 1'b1;
          end
        end
        8'hF0: begin
          nxt_valid   = 1'b1;
          nxt_halted  = 1'b1;
          nxt_retired = retired + 16'd1;
        end
        default: nxt_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e_valid <= 1'b0;
      e_dstE  <= NOREG;
      e_valE  <= '0;
      e_dstM  <= NOREG;
      e_valM  <= '0;
      cc      <= 3'b100;
      halted  <= 1'b0;
      ins_err <= 1'b0;
      retired <= '0;
    end else if (bubble) begin
      e_valid <= 1'b0;
      e_dstE  <= NOREG;
      e_valE  <= '0;
      e_dstM  <= NOREG;
      e_valM  <= '0;
    end else if (!stall) begin
      e_valid <= nxt_valid;
      e_dstE  <= nxt_dstE;
      e_valE  <= nxt_valE;
      e_dstM  <= nxt_dstM;
      e_valM  <= nxt_valM;
      cc      <= nxt_cc;
      halted  <= nxt_halted;
      ins_err <= nxt_err;
      retired <= nxt_retired;
    end
  end

endmodule
